// File: rtl/spill_register.sv
// Valid/ready spill register: cuts all combinational paths between the
// upstream and downstream handshakes using a primary slot (A) and a spill
// slot (B). With Bypass set the stage collapses to plain wires.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset
//   valid_i  upstream payload valid
//   ready_o  upstream ready (from registers only)
//   data_i   upstream payload of type T
//   valid_o  downstream payload valid (from registers only)
//   ready_i  downstream ready
//   data_o   downstream payload of type T (from registers only)
module spill_register #(
  parameter type T      = logic,
  parameter bit  Bypass = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  if (Bypass) begin : gen_bypass
    // Pure feed-through; clock and reset are intentionally unused.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;

    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
  end else begin : gen_spill
    T     a_data_q, b_data_q;
    logic a_full_q, b_full_q;
    logic a_fill, a_drain, b_fill, b_drain;

    // A accepts whenever upstream handshakes; it empties whenever B is free,
    // either straight downstream or into B under backpressure.
    assign a_fill  = valid_i & ready_o;
    assign a_drain = a_full_q & ~b_full_q;
    assign b_fill  = a_drain & ~ready_i;
    assign b_drain = b_full_q & ready_i;

    // Primary slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_data_q <= '0;
        a_full_q <= 1'b0;
      end else begin
        if (a_fill) begin
          a_data_q <= data_i;
        end
        if (a_fill | a_drain) begin
          a_full_q <= a_fill;
        end
      end
    end

    // Spill slot; always holds the older beat when both are full
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        b_data_q <= '0;
        b_full_q <= 1'b0;
      end else begin
        if (b_fill) begin
          b_data_q <= a_data_q;
        end
        if (b_fill | b_drain) begin
          b_full_q <= b_fill;
        end
      end
    end

    assign ready_o = ~a_full_q | ~b_full_q;
    assign valid_o = a_full_q | b_full_q;
    assign data_o  = b_full_q ? b_data_q : a_data_q;

`ifndef SYNTHESIS
    // Downstream handshake rules: a stalled beat must neither vanish nor change.
    logic chk_stall_q;
    T     chk_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        chk_stall_q <= 1'b0;
        chk_data_q  <= '0;
      end else begin
        if (chk_stall_q) begin
          assert (valid_o)
            else $error("spill_register: valid_o dropped without handshake");
          assert (data_o == chk_data_q)
            else $error("spill_register: data_o changed while stalled");
        end
        chk_stall_q <= valid_o & ~ready_i;
        chk_data_q  <= data_o;
      end
    end
`endif
  end

endmodule

// File: tb/tb_spill_register.sv
// Randomized self-checking bench for spill_register: a queue-based model of
// a two-entry in-order buffer predicts valid_o, ready_o and data_o each cycle.
module tb_spill_register;

  typedef logic [7:0] byte_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  valid_i = 1'b0, ready_i = 1'b0;
  byte_t data_i = '0;
  logic  valid_o, ready_o;
  byte_t data_o;

  logic  bp_valid_i = 1'b0, bp_ready_i = 1'b0;
  byte_t bp_data_i = '0;
  logic  bp_valid_o, bp_ready_o;
  byte_t bp_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  byte_t mq[$];
  int    n_in = 0, n_out = 0;
  bit    last_acc;

  always #5 clk = ~clk;

  spill_register #(.T(byte_t), .Bypass(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
  );

  spill_register #(.T(byte_t), .Bypass(1'b1)) dut_bp (
    .clk_i(clk), .rst_ni(rst_n),
    .valid_i(bp_valid_i), .ready_o(bp_ready_o), .data_i(bp_data_i),
    .valid_o(bp_valid_o), .ready_i(bp_ready_i), .data_o(bp_data_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model's buffer contents.
  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(valid_o), 32'(mq.size() > 0));
    check({tag, ".ready"}, 32'(ready_o), 32'(mq.size() < 2));
    if (mq.size() > 0) check({tag, ".data"}, 32'(data_o), 32'(mq[0]));
  endtask

  // Advance one clock: the model sees the inputs present at the edge.
  task automatic step(input string tag);
    bit acc, emi;
    @(posedge clk);
    acc = valid_i && (mq.size() < 2);
    emi = (mq.size() > 0) && ready_i;
    if (emi) begin
      void'(mq.pop_front());
      n_out++;
    end
    if (acc) begin
      mq.push_back(data_i);
      n_in++;
    end
    last_acc = acc;
    #1;
    check_outputs(tag);
  endtask

  initial begin
    byte_t cnt;
    int    sent;
    int    cyc;

    // Reset state
    #2;
    check("rst.valid", 32'(valid_o), 32'd0);
    check("rst.ready", 32'(ready_o), 32'd1);
    check("rst.data", 32'(data_o), 32'd0);
    #10;
    rst_n = 1'b1;
    step("idle");

    // Streaming with ready_i high: one beat per cycle, no bubbles
    ready_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      valid_i = 1'b1;
      data_i  = 8'(i);
      step("stream");
      check("stream.acc", 32'(last_acc), 32'd1);
      check("stream.out", 32'(data_o), 32'(i));
    end
    valid_i = 1'b0;
    step("stream.tail");
    check("stream.empty", 32'(valid_o), 32'd0);

    // Backpressure: fill both slots, then drain in order
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h0A;
    step("bp.a");
    check("bp.ready_after_a", 32'(ready_o), 32'd1);
    data_i = 8'h0B;
    step("bp.b");
    check("bp.ready_after_b", 32'(ready_o), 32'd0);
    check("bp.head", 32'(data_o), 32'h0A);
    data_i = 8'h0C;
    step("bp.stall");
    check("bp.stable", 32'(data_o), 32'h0A);
    ready_i = 1'b1;
    step("bp.drain0");
    check("bp.c_accepted", 32'(last_acc), 32'd0);
    check("bp.out_b", 32'(data_o), 32'h0B);
    step("bp.drain1");
    valid_i = 1'b0;
    check("bp.out_c", 32'(data_o), 32'h0C);
    step("bp.drain2");
    check("bp.empty", 32'(valid_o), 32'd0);

    // Combinational isolation: outputs ignore same-cycle input changes
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h33;
    step("iso.load");
    ready_i = 1'b1;
    #1;
    check("iso.ready_hold", 32'(ready_o), 32'd1);
    valid_i = 1'b0;
    #1;
    check("iso.valid_hold", 32'(valid_o), 32'd1);
    step("iso.after");
    step("iso.idle");

    // Asynchronous reset with both slots full
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h77;
    step("rst2.fill0");
    data_i = 8'h78;
    step("rst2.fill1");
    check("rst2.full", 32'(ready_o), 32'd0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    rst_n   = 1'b0;
    #1;
    mq.delete();
    check("rst2.valid", 32'(valid_o), 32'd0);
    check("rst2.ready", 32'(ready_o), 32'd1);
    check("rst2.data", 32'(data_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b1;
    data_i  = 8'h11;
    step("rst2.first");
    check("rst2.first_data", 32'(data_o), 32'h11);
    valid_i = 1'b0;
    step("rst2.idle");

    // Random valid/ready toggling with a counter payload
    cnt  = 8'h00;
    sent = 0;
    cyc  = 0;
    n_in = 0;
    n_out = 0;
    mq.delete();
    valid_i = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      if (!valid_i || last_acc) begin
        valid_i = ($urandom_range(0, 3) != 0);
        data_i  = cnt;
      end
      ready_i = ($urandom_range(0, 2) != 0);
      step("rand");
      if (last_acc) begin
        sent++;
        cnt = cnt + 8'd1;
      end
      cyc++;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step("rand.drain");
    check("rand.sent", 32'(sent), 32'd1000);
    check("rand.out_count", 32'(n_out), 32'd1000);
    check("rand.empty", 32'(valid_o), 32'd0);

    // Bypass instance: pure wires
    bp_valid_i = 1'b1;
    bp_data_i  = 8'h5A;
    bp_ready_i = 1'b0;
    #1;
    check("byp.valid", 32'(bp_valid_o), 32'd1);
    check("byp.data", 32'(bp_data_o), 32'h5A);
    check("byp.ready0", 32'(bp_ready_o), 32'd0);
    bp_ready_i = 1'b1;
    #1;
    check("byp.ready1", 32'(bp_ready_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
